// File: rtl/snow64_long_mul_u16_by_u8.sv
// rtl/snow64_long_mul_u16_by_u8.sv - sequential radix-16 multiply-accumulate, out = a*b (+c)
// Addend is built only when SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN is defined.
module snow64_long_mul_u16_by_u8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_start,
  input  logic [15:0] in_a,
  input  logic [7:0]  in_b,
  input  logic [7:0]  in_c,
  output logic        out_data_valid,
  output logic        out_can_accept_cmd,
  output logic [23:0] out_data
);
  localparam int WIDTH__IN_A     = 16;
  localparam int WIDTH__IN_B     = 8;
  localparam int WIDTH__OUT_DATA = 24;

  typedef enum logic [1:0] {
    StIdle,
    StStarting,
    StWorking,
    StFinishing
  } state_t;

  state_t                       state;
  logic [WIDTH__IN_A-1:0]       cap_a;
  logic [WIDTH__IN_B-1:0]       cap_b;
  logic [11:0]                  mul_table [16];
  logic [WIDTH__OUT_DATA-1:0]   acc;
  logic [1:0]                   nib_idx;
  logic [3:0]                   cur_nib;
  logic [WIDTH__OUT_DATA-1:0]   acc_next;

`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
  logic [WIDTH__IN_B-1:0]       cap_c;
`else
  logic                         unused_in_c;
  assign unused_in_c = ^in_c;
`endif

  // Multiplicand is consumed MSB nibble first; each step shifts in one table product.
  assign cur_nib  = cap_a[{nib_idx, 2'b00} +: 4];
  assign acc_next = {acc[19:0], 4'b0000} + {12'b0, mul_table[cur_nib]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= StIdle;
      cap_a              <= '0;
      cap_b              <= '0;
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
      cap_c              <= '0;
`endif
      for (int k = 0; k < 16; k++) mul_table[k] <= '0;
      acc                <= '0;
      nib_idx            <= '0;
      out_data_valid     <= 1'b0;
      out_can_accept_cmd <= 1'b1;
      out_data           <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_start) begin
            cap_a              <= in_a;
            cap_b              <= in_b;
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
            cap_c              <= in_c;
`endif
            out_data_valid     <= 1'b0;
            out_can_accept_cmd <= 1'b0;
            state              <= StStarting;
          end
        end
        StStarting: begin
          for (int k = 0; k < 16; k++) mul_table[k] <= {4'b0000, cap_b} * 12'(k);
          acc     <= '0;
          nib_idx <= 2'd3;
          state   <= StWorking;
        end
        StWorking: begin
          acc     <= acc_next;
          nib_idx <= nib_idx - 2'd1;
          if (nib_idx == 2'd0) begin
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
            state              <= StFinishing;
`else
            out_data           <= acc_next;
            out_data_valid     <= 1'b1;
            out_can_accept_cmd <= 1'b1;
            state              <= StIdle;
`endif
          end
        end
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
        StFinishing: begin
          out_data           <= acc + {16'b0, cap_c};
          out_data_valid     <= 1'b1;
          out_can_accept_cmd <= 1'b1;
          state              <= StIdle;
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_snow64_long_mul_u16_by_u8.sv
// tb/tb_snow64_long_mul_u16_by_u8.sv - randomized self-checking bench against a transaction-level model
module tb_snow64_long_mul_u16_by_u8;
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
  localparam int  LAT     = 6;
  localparam bit  ADD_EN  = 1'b1;
`else
  localparam int  LAT     = 5;
  localparam bit  ADD_EN  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_start;
  logic [15:0] in_a;
  logic [7:0]  in_b;
  logic [7:0]  in_c;
  logic        out_data_valid;
  logic        out_can_accept_cmd;
  logic [23:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_busy;
  bit          m_valid;
  logic [23:0] m_data;
  logic [23:0] m_res;
  int          m_done;
  int          cyc = 0;

  snow64_long_mul_u16_by_u8 dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_start           (in_start),
    .in_a               (in_a),
    .in_b               (in_b),
    .in_c               (in_c),
    .out_data_valid     (out_data_valid),
    .out_can_accept_cmd (out_can_accept_cmd),
    .out_data           (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_mac(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c);
    longint r;
    r = longint'(a) * longint'(b) + (ADD_EN ? longint'(c) : 64'd0);
    return r[23:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_res   = '0;
    m_done  = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, check on the falling edge.
  task automatic step(input bit st, input logic [15:0] a, input logic [7:0] b, input logic [7:0] c);
    in_start = st;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    @(posedge clk);
    if (m_busy) begin
      if (cyc == m_done) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
        m_data  = m_res;
      end
    end else if (st) begin
      m_busy  = 1'b1;
      m_valid = 1'b0;
      m_done  = cyc + LAT;
      m_res   = ref_mac(a, b, c);
    end
    cyc++;
    @(negedge clk);
    check_eq("valid", 32'(out_data_valid), 32'(m_valid));
    check_eq("can_accept", 32'(out_can_accept_cmd), 32'(!m_busy));
    check_eq("data", 32'(out_data), 32'(m_data));
  endtask

  task automatic step_idle_rand();
    step(1'b0, 16'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic run_cmd(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c);
    step(1'b1, a, b, c);
    repeat (LAT) step_idle_rand();
    step_idle_rand();
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [15:0] q;
    logic [7:0]  r;

    rst_n    = 1'b0;
    in_start = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_c     = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(out_data_valid), 32'd0);
    check_eq("rst_can_accept", 32'(out_can_accept_cmd), 32'd1);
    check_eq("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    step_idle_rand();

    run_cmd(16'h1234, 8'h56, 8'h78);
    check_eq("basic_const", 32'(out_data), ADD_EN ? 32'h061DF0 : 32'h061D78);
    run_cmd(16'hFFFF, 8'hFF, 8'hFF);
    check_eq("extreme_const", 32'(out_data), ADD_EN ? 32'hFF0000 : 32'hFEFF01);
    run_cmd(16'hABCD, 8'h00, 8'h12);
    run_cmd(16'h0000, 8'h80, 8'h00);

    // Start held high with changing operands: captures only when idle.
    for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 8'($urandom), 8'($urandom));
    repeat (LAT + 1) step_idle_rand();

    // Asynchronous reset in the middle of a command.
    step(1'b1, 16'hBEEF, 8'h5A, 8'h33);
    repeat (3) step_idle_rand();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_data_valid), 32'd0);
    check_eq("async_rst_can_accept", 32'(out_can_accept_cmd), 32'd1);
    check_eq("async_rst_data", 32'(out_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(16'd3, 8'd5, 8'd1);
    check_eq("post_rst_const", 32'(out_data), ADD_EN ? 32'h10 : 32'h0F);

    // Rebuild dividends from divider outputs.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(255, 1));
      q  = ra / 16'(rb);
      r  = 8'(ra % 16'(rb));
      run_cmd(q, rb, r);
      check_eq("round_trip", 32'(out_data), ADD_EN ? 32'(ra) : 32'(q * rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
